// File: rtl/color_bounce_pkg.sv
// Shared constants, state enum and platform geometry helper for the frame drawer.
// FRAME_DRAWER_ERASE_EN adds the ERASE_BALL state to the enum.
package color_bounce_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int BALL_X    = 78;
    localparam int BALL_SIZE = 4;
    localparam int PLAT_W    = 40;
    localparam int NUM_PLATS = 4;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
`ifdef FRAME_DRAWER_ERASE_EN
        ERASE_BALL,
`endif
        DRAW_PLATS,
        DRAW_BALL,
        DONE
    } state_t;

    function automatic logic [7:0] plat_x0(input logic [1:0] idx);
        return 8'(idx) * 8'(PLAT_W);
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Raster-order x/y offset counter for a rectangle of (w_m1+1) x (h_m1+1) pixels.
// Wraps to (0,0) after the last pixel so consecutive objects need no clear.
module rect_scanner (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       step,
    input  logic [5:0] w_m1,
    input  logic [1:0] h_m1,
    output logic [5:0] off_x,
    output logic [1:0] off_y,
    output logic       start,
    output logic       last
);

    logic [5:0] x_q, x_d;
    logic [1:0] y_q, y_d;

    assign off_x = x_q;
    assign off_y = y_q;
    assign start = (x_q == 6'd0) && (y_q == 2'd0);
    assign last  = (x_q == w_m1) && (y_q == h_m1);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = 6'd0;
            y_d = 2'd0;
        end else if (step) begin
            if (x_q == w_m1) begin
                x_d = 6'd0;
                y_d = (y_q == h_m1) ? 2'd0 : y_q + 2'd1;
            end else begin
                x_d = x_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q <= 6'd0;
            y_q <= 2'd0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/frame_drawer.sv
// Draws one frame (optional ball erase, four platforms, ball) as a registered pixel stream.
// Define FRAME_DRAWER_ERASE_EN to erase the previous ball position first.
module frame_drawer
    import color_bounce_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  prev_ball,
    input  logic [7:0]  curr_ball,
    input  logic [27:0] position_plats,
    input  logic [11:0] color_plats,
    input  logic [2:0]  color_ball,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic        done,
    output state_t      dbg_state
);

    state_t      state_q, state_d;
    logic [7:0]  prev_q, prev_d, curr_q, curr_d;
    logic [27:0] pos_q, pos_d;
    logic [11:0] colp_q, colp_d;
    logic [2:0]  colb_q, colb_d;
    logic [1:0]  idx_q, idx_d;
    logic        drain_q, drain_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  c_q, c_d;
    logic        plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic [5:0]  scan_w_m1, off_x;
    logic [1:0]  scan_h_m1, off_y;
    logic        scan_step, scan_start, scan_last;
    logic [7:0]  pix_x;
    logic [8:0]  pix_y;
    logic [2:0]  pix_c;

    rect_scanner u_scan (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state_q == IDLE),
        .step   (scan_step),
        .w_m1   (scan_w_m1),
        .h_m1   (scan_h_m1),
        .off_x  (off_x),
        .off_y  (off_y),
        .start  (scan_start),
        .last   (scan_last)
    );

    // Geometry of the pixel the scanner currently points at.
    always_comb begin
        scan_w_m1 = 6'(BALL_SIZE - 1);
        scan_h_m1 = 2'(BALL_SIZE - 1);
        pix_x     = 8'(BALL_X) + 8'(off_x);
        pix_y     = 9'(curr_q) + 9'(off_y);
        pix_c     = colb_q;
        case (state_q)
`ifdef FRAME_DRAWER_ERASE_EN
            ERASE_BALL: begin
                pix_y = 9'(prev_q) + 9'(off_y);
                pix_c = COLOUR_BLACK;
            end
`endif
            DRAW_PLATS: begin
                scan_w_m1 = 6'(PLAT_W - 1);
                scan_h_m1 = 2'd0;
                pix_x     = plat_x0(idx_q) + 8'(off_x);
                pix_y     = 9'(pos_q[int'(idx_q) * 7 +: 7]);
                pix_c     = colp_q[int'(idx_q) * 3 +: 3];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        curr_d    = curr_q;
        pos_d     = pos_q;
        colp_d    = colp_q;
        colb_d    = colb_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        x_d       = x_q;
        y_d       = y_q;
        c_d       = c_q;
        plot_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        scan_step = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    prev_d  = prev_ball;
                    curr_d  = curr_ball;
                    pos_d   = position_plats;
                    colp_d  = color_plats;
                    colb_d  = color_ball;
                    idx_d   = 2'd0;
                    drain_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef FRAME_DRAWER_ERASE_EN
                    state_d = ERASE_BALL;
`else
                    state_d = DRAW_PLATS;
`endif
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                // The final ball pixel leaves the scanner back at (0,0); one
                // drain cycle separates it from DONE.
                if (state_q == DRAW_BALL && drain_q && scan_start) begin
                    drain_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    scan_step = 1'b1;
                    x_d       = pix_x;
                    y_d       = pix_y[6:0];
                    c_d       = pix_c;
                    plot_d    = (pix_y < 9'(SCREEN_H));
                    if (scan_last) begin
                        if (state_q == DRAW_BALL) begin
                            drain_d = 1'b1;
                        end else if (state_q == DRAW_PLATS) begin
                            idx_d = idx_q + 2'd1;
                            if (idx_q == 2'(NUM_PLATS - 1)) state_d = DRAW_BALL;
                        end else begin
                            state_d = DRAW_PLATS;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            prev_q  <= 8'd0;
            curr_q  <= 8'd0;
            pos_q   <= 28'd0;
            colp_q  <= 12'd0;
            colb_q  <= 3'd0;
            idx_q   <= 2'd0;
            drain_q <= 1'b0;
            x_q     <= 8'd0;
            y_q     <= 7'd0;
            c_q     <= 3'd0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            curr_q  <= curr_d;
            pos_q   <= pos_d;
            colp_q  <= colp_d;
            colb_q  <= colb_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = c_q;
    assign vga_plot   = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/frame_drawer.md
FRAME_DRAWER -- requirements
Module: frame_drawer

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 resetn  in  1  one clock; reset is synchronous and active-low.
REQ-003 start  in  1  draw request from the game controller; one-cycle pulse.
REQ-004 prev_ball  in  8  ball y of the previous frame (top row of the ball).
REQ-005 curr_ball  in  8  ball y of the new frame.
REQ-006 position_plats  in  28  four 7-bit platform y values; platform i is [7i+6:7i].
REQ-007 color_plats  in  12  four 3-bit platform colours; platform i is [3i+2:3i].
REQ-008 color_ball  in  3  ball colour.
REQ-009 vga_x  out  8  pixel x for the VGA adapter.
REQ-010 vga_y  out  7  pixel y for the VGA adapter.
REQ-011 vga_colour  out  3  pixel colour.
REQ-012 vga_plot  out  1  pixel write strobe; high means vga_x/vga_y/vga_colour are valid this cycle.
REQ-013 busy  out  1  high while a frame is being drawn.
REQ-014 done  out  1  one-cycle pulse when a frame is complete.

Function
REQ-015 The screen is 160x120; the ball is a 4x4 square at x 78..81, rows y..y+3; platform i is a 40x1 line at x 40i..40i+39, row position_plats[i].
REQ-016 The FSM states are IDLE, ERASE_BALL, DRAW_PLATS, DRAW_BALL and DONE.
REQ-017 In IDLE, start=1 latches all data inputs and moves to ERASE_BALL; the block ignores input changes after the latch.
REQ-018 start is ignored in every state other than IDLE; it is never queued.
REQ-019 ERASE_BALL plots 16 pixels of the prev_ball square in colour 000, DRAW_PLATS plots 160 pixels for platforms 0..3 in order, and DRAW_BALL plots 16 pixels of the curr_ball square in color_ball.
REQ-020 Within each object, x increments fastest and then y (raster order); one pixel is produced per cycle with no gaps.
REQ-021 All VGA outputs are registered; if start is sampled at edge 0, the first pixel is valid after edge 1, the 192nd pixel is valid after edge 192, and the block enters DONE at edge 193.
REQ-022 In DONE, done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-023 busy=1 from the edge after start through the DONE cycle inclusive, and busy=0 in IDLE.
REQ-024 A pixel whose y >= 120 still consumes its cycle with vga_plot=0; vga_y is the low 7 bits of y, and vga_x is 8 bits wide with no wrap.
REQ-025 Outside active plot cycles, vga_plot=0, and vga_x, vga_y and vga_colour hold their last values.

Reset
REQ-026 On resetn=0 at a clk edge the FSM enters IDLE, and vga_x, vga_y, vga_colour, vga_plot, busy and done all become 0.
REQ-027 A reset during a draw abandons the frame; no further pixels are produced and done is not pulsed.
REQ-028 When resetn=0 and start=1 occur together, reset wins.

Configuration
REQ-029 The macro FRAME_DRAWER_ERASE_EN is defined: the ERASE_BALL state exists and a frame is 192 pixels.
REQ-030 The macro FRAME_DRAWER_ERASE_EN is undefined: ERASE_BALL is removed, start goes directly to DRAW_PLATS, a frame is 176 pixels, and DONE is entered at edge 177.

Structure
REQ-031 The package color_bounce_pkg holds the shared constants and the state enum:
- SCREEN_W=160, SCREEN_H=120
- BALL_X=78, BALL_SIZE=4, PLAT_W=40, NUM_PLATS=4
- COLOUR_BLACK=3'b000
- the state enum
REQ-032 The sub-module rect_scanner holds the x/y offset counters for a WxH rectangle, with start and last outputs; the FSM reuses it for every object.

Verification
REQ-033 Reset: hold resetn=0 for 2 cycles -> all outputs 0 and the FSM in IDLE.
REQ-034 Full frame:
- Stimulus: prev=10, curr=11, plats y={20,40,60,80}, colours={1,2,3,4}, ball colour 5, start.
- Response: 192 plots; first (78,10,0); 17th (0,20,1); 177th (78,11,5); last (81,14,5); done at edge 193.
REQ-035 Clipping: curr_ball=118 -> ball rows 118 and 119 give 8 plots with vga_plot=1; rows 120 and 121 consume 8 cycles with vga_plot=0; done still arrives at edge 193.
REQ-036 Start while busy: pulse start at edges 0 and 50 -> exactly 192 plots and exactly one done pulse.
REQ-037 Reset mid-operation: resetn=0 at edge 100 -> vga_plot=0, busy=0 and done=0 from the next cycle; a later start draws a full frame.
REQ-038 FRAME_DRAWER_ERASE_EN undefined: same stimulus as REQ-034 -> 176 plots; first (0,20,1); done at edge 177.
